// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the unified-memory arbiter and its latency counter:
// FSM state encoding, access-owner encoding, default bus widths, counter
// widths and a saturating-increment helper for the IF starvation counter.
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   // Latency counter holds MEM_LAT (1..15); starve counter holds MAX_STARVE (1..7).
   localparam int CNT_W    = 4;
   localparam int STARVE_W = 3;

   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                   input logic [STARVE_W-1:0] lim);
      return (v >= lim) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_lat_counter
// Loadable down-counter with a "last cycle" flag. Loaded with a latency value,
// it counts down while enabled and flags the cycle in which the count is 1,
// i.e. the final cycle of the timed interval. Usable for any fixed-latency
// sequencing (memory accesses, cache-refill beats).
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous reset, active-low (count cleared to 0)
//   load_i     in   load load_val_i this cycle (takes priority over en_i)
//   load_val_i in   value to load
//   en_i       in   decrement enable; the count stops at 0
//   done_o     out  count == 1 (last cycle of the interval)
// -----------------------------------------------------------------------------
module mem_lat_counter
   import cpu_mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// requester (IF) and the data-memory requester (DM). One access is in flight
// at a time. DM has priority, except that after MAX_STARVE consecutive DM
// grants while IF is waiting, IF is forced to win the next arbitration.
//
// Timing: the grant, mem_en and the memory address/write data are all
// combinational in the grant cycle T. The arbiter is BUSY in cycles
// T+1..T+MEM_LAT; cycle T+MEM_LAT is the cycle in which mem_rdata is valid,
// so the owner's valid pulse and read data are presented in that cycle and
// the read data is captured into the owner's rdata register at its closing
// edge (the rdata outputs then hold it). A new access may be granted in that
// same final cycle, giving one access per MEM_LAT cycles back-to-back.
//
// Ports:
//   clk        in   clock
//   Rst        in   asynchronous reset, active-low
//   if_req     in   IF read request, held until if_gnt
//   if_addr    in   IF read address
//   if_gnt     out  IF request accepted this cycle
//   if_valid   out  IF read data valid (one cycle)
//   if_rdata   out  IF read data
//   dm_req     in   DM request, held until dm_gnt
//   dm_we      in   DM write (1) / read (0)
//   dm_addr    in   DM address
//   dm_wdata   in   DM write data
//   dm_gnt     out  DM request accepted this cycle
//   dm_valid   out  DM read data valid or write completion (one cycle)
//   dm_rdata   out  DM read data, 0 for writes
//   mem_en     out  memory access strobe, one cycle per access
//   mem_we     out  memory write enable, qualified by mem_en
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid MEM_LAT cycles after mem_en
//   busy       out  access outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MEM_LAT    = 2,
   parameter int MAX_STARVE = 3
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..15");
   end
   if ((MAX_STARVE < 1) || (MAX_STARVE > 7)) begin : g_bad_max_starve
      $error("mem_port_arbiter: MAX_STARVE must be in 1..7");
   end

   localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LAT);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(MAX_STARVE);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                is_wr_q, is_wr_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

   logic lat_done;
   logic done;
   logic can_arb;
   logic dm_win;
   logic if_win;

   mem_lat_counter u_lat_cnt (
      .clk        (clk),
      .rst_n      (Rst),
      .load_i     (mem_en),
      .load_val_i (LAT_LOAD),
      .en_i       (state_q == ST_BUSY),
      .done_o     (lat_done)
   );

   // Final cycle of the outstanding access: memory data is valid now.
   assign done = (state_q == ST_BUSY) && lat_done;

   // Gating with Rst keeps every output low while reset is asserted, even if
   // requesters hold their request lines high.
   assign can_arb = Rst && ((state_q == ST_IDLE) || done);
   assign dm_win  = can_arb && dm_req && !(if_req && (starve_q == STARVE_LIM));
   assign if_win  = can_arb && if_req && !dm_win;

   always_comb begin
      if_gnt    = if_win;
      dm_gnt    = dm_win;
      mem_en    = if_win || dm_win;
      mem_we    = dm_win && dm_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dm_win) begin
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (if_win) begin
         mem_addr  = if_addr;
      end

      if_valid = done && (owner_q == OWN_IF);
      dm_valid = done && (owner_q == OWN_DM);
      if_rdata = if_valid ? mem_rdata : if_rdata_q;
      dm_rdata = dm_rdata_q;
      if (dm_valid) begin
         dm_rdata = is_wr_q ? '0 : mem_rdata;
      end
      busy = (state_q == ST_BUSY);
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      is_wr_d    = is_wr_q;
      starve_d   = starve_q;
      if_rdata_d = if_valid ? mem_rdata : if_rdata_q;
      dm_rdata_d = dm_valid ? dm_rdata : dm_rdata_q;

      if (dm_win || if_win) begin
         state_d = ST_BUSY;
         owner_d = dm_win ? OWN_DM : OWN_IF;
         is_wr_d = dm_win && dm_we;
      end else if (done) begin
         state_d = ST_IDLE;
      end

      // Starvation only accrues while IF is actually waiting.
      if (!if_req) begin
         starve_d = '0;
      end else if (dm_win) begin
         starve_d = sat_inc(starve_q, STARVE_LIM);
      end else if (if_win) begin
         starve_d = '0;
      end
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         is_wr_q    <= 1'b0;
         starve_q   <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         is_wr_q    <= is_wr_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the instruction-fetch requester (IF) and the data-memory requester (DM, from the MEM pipeline stage).
- Grants one access at a time, tracks the access latency with a counter, and returns read data/acks on a valid pulse.
- Applies DM-first priority with a starvation guard for IF.
- Sits between the CPU pipeline (in place of separate I/D memories) and the memory macro.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 2, cycles from mem_en to mem_rdata valid; legal range 1..15.
- MAX_STARVE, 3, consecutive DM grants while IF waits before IF is forced to win; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous reset, active-low.
- if_req  in  1  IF read request; held until if_gnt.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  IF request accepted this cycle.
- if_valid  out  1  IF read data valid.
- if_rdata  out  DATA_W  IF read data.
- dm_req  in  1  DM request; held until dm_gnt.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  DM address.
- dm_wdata  in  DATA_W  DM write data.
- dm_gnt  out  1  DM request accepted this cycle.
- dm_valid  out  1  DM read data valid, or write completion ack.
- dm_rdata  out  DATA_W  DM read data; 0 for writes.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  access outstanding (state BUSY).

Behaviour:
- Reset (Rst=0, async):
  - state=IDLE, counter=0, starve=0, owner=IF.
  - All outputs are 0. if_rdata and dm_rdata registers are cleared.
  - An outstanding access is abandoned: no valid is issued for it after reset releases.
- FSM has two states, IDLE and BUSY.
- IDLE, no request: all strobes are 0.
- IDLE, request present: arbitration is combinational in cycle T.
  - DM wins if dm_req=1 and not (if_req=1 and starve==MAX_STARVE); otherwise IF wins if if_req=1.
  - Winner's gnt=1 in cycle T.
  - mem_en=1, mem_we=(DM & dm_we), mem_addr/mem_wdata = winner's inputs, all combinationally in T. mem_we=0 and mem_wdata=0 for IF.
  - Registered at the edge ending T: owner, is_write; counter=MEM_LAT; state=BUSY.
- BUSY:
  - Counter decrements each cycle; gnt=0, mem_en=0.
  - When counter reaches 1, the next edge captures mem_rdata into the owner's rdata register (dm_rdata=0 for writes). That edge also sets owner's valid=1 for exactly one cycle (cycle T+MEM_LAT) and sets state=IDLE.
- Back-to-back: a new grant may occur in the same cycle valid is high. Peak throughput is one access per MEM_LAT cycles; with MEM_LAT=1, one per cycle.
- Starve counter, updated at each grant:
  - DM granted while if_req=1: starve+1, saturating at MAX_STARVE.
  - IF granted: starve=0.
  - Cycle with if_req=0: starve=0.
- busy = (state==BUSY).
- Requests that drop before their grant are ignored with no side effects.
- Requester inputs are not sampled after the grant cycle.
- Simultaneous if_req and dm_req, starve<MAX_STARVE: DM wins; IF waits.
- Counter width is 4 bits. MEM_LAT outside 1..15 is a configuration error; the RTL carries an elaboration-time check.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - the state encoding (ST_IDLE=1'b0, ST_BUSY=1'b1);
  - owner encoding (OWN_IF=0, OWN_DM=1);
  - default ADDR_W/DATA_W=16.
- One natural sub-module, mem_lat_counter: loadable down-counter with a done flag, reusable for cache-refill sequencing.
- The arbitration logic stays inline.

Test Plan:
- Reset mid-access:
  - Stimulus: MEM_LAT=3, dm read granted at T; Rst=0 at T+1 for one cycle.
  - Required: no dm_valid; busy=0; all outputs 0 immediately (async); next request granted normally.
- Single IF read:
  - Stimulus: MEM_LAT=2, if_req=1, if_addr=16'h0010, memory returns 16'hA5C3.
  - Required: if_gnt and mem_en at T with mem_addr=16'h0010, mem_we=0; if_valid=1 and if_rdata=16'hA5C3 at T+2 only.
- DM write:
  - Stimulus: dm_req=1, dm_we=1, dm_addr=16'h0042, dm_wdata=16'h1234.
  - Required: mem_en=1, mem_we=1, mem_addr=16'h0042, mem_wdata=16'h1234 at T; dm_valid=1, dm_rdata=0 at T+MEM_LAT.
- Contention priority:
  - Stimulus: if_req and dm_req both asserted at T.
  - Required: dm_gnt at T, if_gnt=0; if_gnt at T+MEM_LAT in the same cycle as dm_valid (dm_req dropped).
- Starvation:
  - Stimulus: MAX_STARVE=3, if_req held high, dm_req held high continuously.
  - Required: grant order DM, DM, DM, IF, DM, DM, DM, IF; no IF wait exceeds 3·MEM_LAT cycles.
- Throughput:
  - Stimulus: MEM_LAT=1, dm_req held high with reads to 16'h0000..16'h0004.
  - Required: dm_gnt every cycle; dm_valid every cycle from T+1; busy=1 continuously; data order preserved.
